// File: rtl/fetch_pkg.sv
// Shared types for the fetch -> decode group pipeline.
//   fd_lane_t  : one lane of a fetch group (instruction, PC, immediate,
//                taken prediction, predicted-target PC, history snapshot)
//   fd_group_t : lane mask + three lanes + group RAS top-of-stack checkpoint
//   fd_state_e : occupancy FSM of fetch_decode_pipe (encoding == held groups)
package fetch_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int ENTRIES     = 32;
    localparam int INDEX_WIDTH = $clog2(ENTRIES);
    localparam int GHIST_WIDTH = INDEX_WIDTH + 3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  instr;
        logic [DATA_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]  imm;
        logic                   bp;
        logic [DATA_WIDTH-1:0]  pc_at_pred;
        logic [GHIST_WIDTH-1:0] ghist;
    } fd_lane_t;

    typedef struct packed {
        logic [2:0]     mask;
        fd_lane_t [2:0] lane;
        logic [2:0]     ras_tos;
    } fd_group_t;

    typedef enum logic [1:0] {
        FD_EMPTY = 2'd0,
        FD_ONE   = 2'd1,
        FD_FULL  = 2'd2
    } fd_state_e;

    // Lane masks are always filled from lane 0 upward.
    function automatic logic is_thermo(input logic [2:0] m);
        return (m == 3'b000) || (m == 3'b001) || (m == 3'b011) || (m == 3'b111);
    endfunction

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// Buffer-side and decode-side signals of fetch_decode_pipe.
//   master : the environment (instruction buffer + decode) driving *_i
//   slave  : fetch_decode_pipe, driving *_o
interface fetch_decode_pipe_if;
    import fetch_pkg::*;

    logic                   flush_i;
    logic [2:0]             buf_valid_i;
    logic [2:0]             buf_ready_o;
    logic [DATA_WIDTH-1:0]  instruction_i_0, instruction_i_1, instruction_i_2;
    logic [DATA_WIDTH-1:0]  pc_i_0, pc_i_1, pc_i_2;
    logic [DATA_WIDTH-1:0]  imm_i_0, imm_i_1, imm_i_2;
    logic                   branch_prediction_i_0, branch_prediction_i_1, branch_prediction_i_2;
    logic [DATA_WIDTH-1:0]  pc_at_prediction_i_0, pc_at_prediction_i_1, pc_at_prediction_i_2;
    logic [GHIST_WIDTH-1:0] global_history_i_0, global_history_i_1, global_history_i_2;
    logic [2:0]             ras_tos_checkpoint_i;

    logic                   dec_ready_i;
    logic [2:0]             dec_valid_o;
    logic [DATA_WIDTH-1:0]  instruction_o_0, instruction_o_1, instruction_o_2;
    logic [DATA_WIDTH-1:0]  pc_o_0, pc_o_1, pc_o_2;
    logic [DATA_WIDTH-1:0]  imm_o_0, imm_o_1, imm_o_2;
    logic                   branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2;
    logic [DATA_WIDTH-1:0]  pc_at_prediction_o_0, pc_at_prediction_o_1, pc_at_prediction_o_2;
    logic [GHIST_WIDTH-1:0] global_history_o_0, global_history_o_1, global_history_o_2;
    logic [2:0]             ras_tos_checkpoint_o;
    logic [1:0]             occupancy_o;

    modport master (
        output flush_i, buf_valid_i,
               instruction_i_0, instruction_i_1, instruction_i_2,
               pc_i_0, pc_i_1, pc_i_2, imm_i_0, imm_i_1, imm_i_2,
               branch_prediction_i_0, branch_prediction_i_1, branch_prediction_i_2,
               pc_at_prediction_i_0, pc_at_prediction_i_1, pc_at_prediction_i_2,
               global_history_i_0, global_history_i_1, global_history_i_2,
               ras_tos_checkpoint_i, dec_ready_i,
        input  buf_ready_o, dec_valid_o,
               instruction_o_0, instruction_o_1, instruction_o_2,
               pc_o_0, pc_o_1, pc_o_2, imm_o_0, imm_o_1, imm_o_2,
               branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2,
               pc_at_prediction_o_0, pc_at_prediction_o_1, pc_at_prediction_o_2,
               global_history_o_0, global_history_o_1, global_history_o_2,
               ras_tos_checkpoint_o, occupancy_o
    );

    modport slave (
        input  flush_i, buf_valid_i,
               instruction_i_0, instruction_i_1, instruction_i_2,
               pc_i_0, pc_i_1, pc_i_2, imm_i_0, imm_i_1, imm_i_2,
               branch_prediction_i_0, branch_prediction_i_1, branch_prediction_i_2,
               pc_at_prediction_i_0, pc_at_prediction_i_1, pc_at_prediction_i_2,
               global_history_i_0, global_history_i_1, global_history_i_2,
               ras_tos_checkpoint_i, dec_ready_i,
        output buf_ready_o, dec_valid_o,
               instruction_o_0, instruction_o_1, instruction_o_2,
               pc_o_0, pc_o_1, pc_o_2, imm_o_0, imm_o_1, imm_o_2,
               branch_prediction_o_0, branch_prediction_o_1, branch_prediction_o_2,
               pc_at_prediction_o_0, pc_at_prediction_o_1, pc_at_prediction_o_2,
               global_history_o_0, global_history_o_1, global_history_o_2,
               ras_tos_checkpoint_o, occupancy_o
    );

endinterface

// File: rtl/fd_group_reg.sv
// One fetch-group slot (used for HEAD and SKID).
//   clk, reset : clock, asynchronous active-low reset
//   load       : capture d (mask + payload)
//   clear      : invalidate the slot by zeroing the mask only; wins over load
//   d, q       : group in / registered group out
module fd_group_reg
    import fetch_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  logic      clear,
    input  fd_group_t d,
    output fd_group_t q
);

    // NOTE: payload flops are reset along with the mask because decode must
    // see all-zero outputs while the pipe is held in reset.
    // NOTE: non-blocking assignments so every slot samples pre-edge values;
    // HEAD<=SKID and SKID-clear happen in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q.mask <= 3'b000;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_decode_pipe.sv
// 3-lane group pipeline register with a one-group skid between the fetch
// instruction buffer and the 3-wide decode stage.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : fetch_decode_pipe_if.slave
//                buffer side: flush_i, buf_valid_i, buf_ready_o, lane payload *_i_0..2,
//                             ras_tos_checkpoint_i
//                decode side: dec_ready_i, dec_valid_o, lane payload *_o_0..2,
//                             ras_tos_checkpoint_o, occupancy_o
// Decode sees HEAD flops directly. The buffer is told "ready" only while a
// slot is guaranteed free, so decode's stall never reaches the buffer
// combinationally; SKID absorbs the group that arrives during a stall.
module fetch_decode_pipe
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    fetch_decode_pipe_if.slave bus
);

    fd_state_e  state, state_nxt;
    fd_group_t  in_grp, head_d, head_q, skid_q;
    logic       head_load, head_clear, head_from_skid;
    logic       skid_load, skid_clear;
    logic [2:0] buf_ready;
    logic       push, pop;

    // Incoming group, mask stored exactly as received.
    assign in_grp.mask               = bus.buf_valid_i;
    assign in_grp.ras_tos            = bus.ras_tos_checkpoint_i;
    assign in_grp.lane[0].instr      = bus.instruction_i_0;
    assign in_grp.lane[0].pc         = bus.pc_i_0;
    assign in_grp.lane[0].imm        = bus.imm_i_0;
    assign in_grp.lane[0].bp         = bus.branch_prediction_i_0;
    assign in_grp.lane[0].pc_at_pred = bus.pc_at_prediction_i_0;
    assign in_grp.lane[0].ghist      = bus.global_history_i_0;
    assign in_grp.lane[1].instr      = bus.instruction_i_1;
    assign in_grp.lane[1].pc         = bus.pc_i_1;
    assign in_grp.lane[1].imm        = bus.imm_i_1;
    assign in_grp.lane[1].bp         = bus.branch_prediction_i_1;
    assign in_grp.lane[1].pc_at_pred = bus.pc_at_prediction_i_1;
    assign in_grp.lane[1].ghist      = bus.global_history_i_1;
    assign in_grp.lane[2].instr      = bus.instruction_i_2;
    assign in_grp.lane[2].pc         = bus.pc_i_2;
    assign in_grp.lane[2].imm        = bus.imm_i_2;
    assign in_grp.lane[2].bp         = bus.branch_prediction_i_2;
    assign in_grp.lane[2].pc_at_pred = bus.pc_at_prediction_i_2;
    assign in_grp.lane[2].ghist      = bus.global_history_i_2;

    // Ready depends on state, flush and reset only, never on dec_ready_i.
    assign buf_ready = (state != FD_FULL && !bus.flush_i && reset) ? 3'b111 : 3'b000;
    assign push      = |(bus.buf_valid_i & buf_ready);
    assign pop       = (head_q.mask != 3'b000) && bus.dec_ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FD_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (bus.flush_i) begin
            // Flush beats everything: a concurrent pop is ignored and push is
            // already blocked by buf_ready.
            state_nxt  = FD_EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                FD_EMPTY: begin
                    if (push) begin
                        state_nxt = FD_ONE;
                        head_load = 1'b1;
                    end
                end
                FD_ONE: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        state_nxt = FD_FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_nxt  = FD_EMPTY;
                        head_clear = 1'b1;
                    end
                end
                FD_FULL: begin
                    if (pop) begin
                        state_nxt      = FD_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_nxt  = FD_EMPTY;
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign head_d = head_from_skid ? skid_q : in_grp;

    fd_group_reg u_head (
        .clk   (clk),
        .reset (reset),
        .load  (head_load),
        .clear (head_clear),
        .d     (head_d),
        .q     (head_q)
    );

    fd_group_reg u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_grp),
        .q     (skid_q)
    );

    assign bus.buf_ready_o           = buf_ready;
    assign bus.occupancy_o           = state;
    assign bus.dec_valid_o           = head_q.mask;
    assign bus.ras_tos_checkpoint_o  = head_q.ras_tos;
    assign bus.instruction_o_0       = head_q.lane[0].instr;
    assign bus.pc_o_0                = head_q.lane[0].pc;
    assign bus.imm_o_0               = head_q.lane[0].imm;
    assign bus.branch_prediction_o_0 = head_q.lane[0].bp;
    assign bus.pc_at_prediction_o_0  = head_q.lane[0].pc_at_pred;
    assign bus.global_history_o_0    = head_q.lane[0].ghist;
    assign bus.instruction_o_1       = head_q.lane[1].instr;
    assign bus.pc_o_1                = head_q.lane[1].pc;
    assign bus.imm_o_1               = head_q.lane[1].imm;
    assign bus.branch_prediction_o_1 = head_q.lane[1].bp;
    assign bus.pc_at_prediction_o_1  = head_q.lane[1].pc_at_pred;
    assign bus.global_history_o_1    = head_q.lane[1].ghist;
    assign bus.instruction_o_2       = head_q.lane[2].instr;
    assign bus.pc_o_2                = head_q.lane[2].pc;
    assign bus.imm_o_2               = head_q.lane[2].imm;
    assign bus.branch_prediction_o_2 = head_q.lane[2].bp;
    assign bus.pc_at_prediction_o_2  = head_q.lane[2].pc_at_pred;
    assign bus.global_history_o_2    = head_q.lane[2].ghist;

    a_buf_valid_thermo: assert property (@(posedge clk) disable iff (!reset)
        is_thermo(bus.buf_valid_i));
    a_dec_valid_thermo: assert property (@(posedge clk) disable iff (!reset)
        is_thermo(head_q.mask));
    a_buf_ready_all_or_none: assert property (@(posedge clk) disable iff (!reset)
        (buf_ready == 3'b000) || (buf_ready == 3'b111));
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!reset)
        !(state == FD_FULL && push));

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed and randomised checks of fetch_decode_pipe: reset, streaming,
// stall into the skid slot, flush, push+pop in ONE, and payload integrity
// against a two-deep reference queue.
module tb_fetch_decode_pipe;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_decode_pipe_if bus ();

    fetch_decode_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic fd_group_t make_group(input logic [2:0] mask, input logic [31:0] pc,
                                             input logic [2:0] ras);
        fd_group_t g;
        g.mask    = mask;
        g.ras_tos = ras;
        for (int k = 0; k < 3; k++) begin
            g.lane[k].instr      = ~(pc + 32'(4 * k));
            g.lane[k].pc         = pc + 32'(4 * k);
            g.lane[k].imm        = (pc + 32'(4 * k)) ^ 32'h5A5A_5A5A;
            g.lane[k].bp         = (k == 1);
            g.lane[k].pc_at_pred = pc + 32'h40;
            g.lane[k].ghist      = pc[7:0] ^ 8'(k);
        end
        return g;
    endfunction

    function automatic fd_group_t rand_group(input logic [2:0] mask);
        fd_group_t   g;
        logic [31:0] r;
        g.mask = mask;
        r = $urandom;
        g.ras_tos = r[2:0];
        for (int k = 0; k < 3; k++) begin
            g.lane[k].instr      = $urandom;
            g.lane[k].pc         = $urandom;
            g.lane[k].imm        = $urandom;
            g.lane[k].pc_at_pred = $urandom;
            r = $urandom;
            g.lane[k].bp    = r[8];
            g.lane[k].ghist = r[GHIST_WIDTH-1:0];
        end
        return g;
    endfunction

    task automatic drive_group(input fd_group_t g);
        bus.buf_valid_i           = g.mask;
        bus.ras_tos_checkpoint_i  = g.ras_tos;
        bus.instruction_i_0       = g.lane[0].instr;
        bus.pc_i_0                = g.lane[0].pc;
        bus.imm_i_0               = g.lane[0].imm;
        bus.branch_prediction_i_0 = g.lane[0].bp;
        bus.pc_at_prediction_i_0  = g.lane[0].pc_at_pred;
        bus.global_history_i_0    = g.lane[0].ghist;
        bus.instruction_i_1       = g.lane[1].instr;
        bus.pc_i_1                = g.lane[1].pc;
        bus.imm_i_1               = g.lane[1].imm;
        bus.branch_prediction_i_1 = g.lane[1].bp;
        bus.pc_at_prediction_i_1  = g.lane[1].pc_at_pred;
        bus.global_history_i_1    = g.lane[1].ghist;
        bus.instruction_i_2       = g.lane[2].instr;
        bus.pc_i_2                = g.lane[2].pc;
        bus.imm_i_2               = g.lane[2].imm;
        bus.branch_prediction_i_2 = g.lane[2].bp;
        bus.pc_at_prediction_i_2  = g.lane[2].pc_at_pred;
        bus.global_history_i_2    = g.lane[2].ghist;
    endtask

    function automatic fd_group_t head_seen();
        fd_group_t g;
        g.mask             = bus.dec_valid_o;
        g.ras_tos          = bus.ras_tos_checkpoint_o;
        g.lane[0].instr      = bus.instruction_o_0;
        g.lane[0].pc         = bus.pc_o_0;
        g.lane[0].imm        = bus.imm_o_0;
        g.lane[0].bp         = bus.branch_prediction_o_0;
        g.lane[0].pc_at_pred = bus.pc_at_prediction_o_0;
        g.lane[0].ghist      = bus.global_history_o_0;
        g.lane[1].instr      = bus.instruction_o_1;
        g.lane[1].pc         = bus.pc_o_1;
        g.lane[1].imm        = bus.imm_o_1;
        g.lane[1].bp         = bus.branch_prediction_o_1;
        g.lane[1].pc_at_pred = bus.pc_at_prediction_o_1;
        g.lane[1].ghist      = bus.global_history_o_1;
        g.lane[2].instr      = bus.instruction_o_2;
        g.lane[2].pc         = bus.pc_o_2;
        g.lane[2].imm        = bus.imm_o_2;
        g.lane[2].bp         = bus.branch_prediction_o_2;
        g.lane[2].pc_at_pred = bus.pc_at_prediction_o_2;
        g.lane[2].ghist      = bus.global_history_o_2;
        return g;
    endfunction

    fd_group_t model_q[$];

    initial begin
        drive_group('0);
        bus.flush_i     = 1'b0;
        bus.dec_ready_i = 1'b0;

        // Power-on reset
        #1 reset = 1'b0;
        #2;
        check("rst_buf_ready", 512'(bus.buf_ready_o), 512'(3'b000));
        check("rst_dec_valid", 512'(bus.dec_valid_o), 512'(3'b000));
        check("rst_occupancy", 512'(bus.occupancy_o), 512'(2'd0));
        check("rst_payload",   512'(head_seen()),     512'(fd_group_t'('0)));
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("rel_buf_ready", 512'(bus.buf_ready_o), 512'(3'b111));

        // Stream at full rate
        bus.dec_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_group(make_group(3'b111, 32'h100 + 32'(12 * k), 3'(k)));
            tick();
            check("stream_valid", 512'(bus.dec_valid_o), 512'(3'b111));
            check("stream_pc",    512'(bus.pc_o_0),      512'(32'h100 + 32'(12 * k)));
            check("stream_occ",   512'(bus.occupancy_o), 512'(2'd1));
        end
        bus.buf_valid_i = 3'b000;
        tick();
        check("drain_occ",   512'(bus.occupancy_o), 512'(2'd0));
        check("drain_valid", 512'(bus.dec_valid_o), 512'(3'b000));

        // Stall: second group lands in SKID
        bus.dec_ready_i = 1'b0;
        drive_group(make_group(3'b011, 32'h100, 3'd1));
        tick();
        check("stall_head1", 512'(head_seen()), 512'(make_group(3'b011, 32'h100, 3'd1)));
        drive_group(make_group(3'b111, 32'h108, 3'd2));
        tick();
        bus.buf_valid_i = 3'b000;
        #1;
        check("stall_occ",       512'(bus.occupancy_o), 512'(2'd2));
        check("stall_buf_ready", 512'(bus.buf_ready_o), 512'(3'b000));
        check("stall_hold_pc",   512'(bus.pc_o_0),      512'(32'h100));
        bus.dec_ready_i = 1'b1;
        #1;
        check("stall_pop1_valid", 512'(bus.dec_valid_o), 512'(3'b011));
        tick();
        check("stall_head2", 512'(head_seen()),     512'(make_group(3'b111, 32'h108, 3'd2)));
        check("stall_occ1",  512'(bus.occupancy_o), 512'(2'd1));
        tick();
        check("stall_empty_valid", 512'(bus.dec_valid_o), 512'(3'b000));
        check("stall_empty_occ",   512'(bus.occupancy_o), 512'(2'd0));

        // Flush while FULL, decode ready and buffer offering a group
        bus.dec_ready_i = 1'b0;
        drive_group(make_group(3'b111, 32'h300, 3'd3));
        tick();
        drive_group(make_group(3'b111, 32'h30C, 3'd4));
        tick();
        check("flush_pre_occ", 512'(bus.occupancy_o), 512'(2'd2));
        drive_group(make_group(3'b111, 32'h400, 3'd5));
        bus.flush_i     = 1'b1;
        bus.dec_ready_i = 1'b1;
        #1;
        check("flush_buf_ready", 512'(bus.buf_ready_o), 512'(3'b000));
        tick();
        check("flush_valid", 512'(bus.dec_valid_o), 512'(3'b000));
        check("flush_occ",   512'(bus.occupancy_o), 512'(2'd0));
        bus.flush_i     = 1'b0;
        bus.buf_valid_i = 3'b000;
        #1;
        check("post_flush_buf_ready", 512'(bus.buf_ready_o), 512'(3'b111));
        tick();
        check("post_flush_valid", 512'(bus.dec_valid_o), 512'(3'b000));
        check("post_flush_occ",   512'(bus.occupancy_o), 512'(2'd0));

        // Push and pop together in ONE
        bus.dec_ready_i = 1'b1;
        drive_group(make_group(3'b111, 32'h1F0, 3'd6));
        tick();
        check("one_first_pc", 512'(bus.pc_o_0), 512'(32'h1F0));
        drive_group(make_group(3'b001, 32'h200, 3'd7));
        tick();
        check("one_pp_occ",   512'(bus.occupancy_o), 512'(2'd1));
        check("one_pp_valid", 512'(bus.dec_valid_o), 512'(3'b001));
        check("one_pp_pc",    512'(bus.pc_o_0),      512'(32'h200));
        bus.buf_valid_i = 3'b000;
        tick();
        check("one_drain_occ", 512'(bus.occupancy_o), 512'(2'd0));

        // Reset asserted mid-stream with two groups held
        bus.dec_ready_i = 1'b0;
        drive_group(make_group(3'b111, 32'h500, 3'd1));
        tick();
        drive_group(make_group(3'b011, 32'h50C, 3'd2));
        tick();
        bus.buf_valid_i = 3'b000;
        check("mid_pre_occ", 512'(bus.occupancy_o), 512'(2'd2));
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid",     512'(bus.dec_valid_o), 512'(3'b000));
        check("mid_rst_occ",       512'(bus.occupancy_o), 512'(2'd0));
        check("mid_rst_buf_ready", 512'(bus.buf_ready_o), 512'(3'b000));
        check("mid_rst_pc",        512'(bus.pc_o_0),      512'(32'h0));
        #3 reset = 1'b1;
        #1;
        check("mid_rel_buf_ready", 512'(bus.buf_ready_o), 512'(3'b111));
        tick();
        check("mid_rel_valid", 512'(bus.dec_valid_o), 512'(3'b000));

        // Random traffic against a two-deep reference queue
        model_q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            fd_group_t  g;
            logic [2:0] m;
            logic [2:0] exp_ready;
            logic       fl, rdy, do_push, do_pop;
            case ($urandom_range(0, 3))
                0:       m = 3'b000;
                1:       m = 3'b001;
                2:       m = 3'b011;
                default: m = 3'b111;
            endcase
            g   = rand_group(m);
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            drive_group(g);
            bus.flush_i     = fl;
            bus.dec_ready_i = rdy;
            #1;
            exp_ready = (model_q.size() < 2 && !fl) ? 3'b111 : 3'b000;
            check("rnd_buf_ready", 512'(bus.buf_ready_o), 512'(exp_ready));
            do_push = (m != 3'b000) && (exp_ready == 3'b111);
            do_pop  = (model_q.size() > 0) && rdy;
            tick();
            if (fl) begin
                model_q.delete();
            end else begin
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back(g);
            end
            check("rnd_occ", 512'(bus.occupancy_o), 512'(model_q.size()));
            if (model_q.size() > 0) begin
                check("rnd_group", 512'(head_seen()),              512'(model_q[0]));
                check("rnd_ras",   512'(bus.ras_tos_checkpoint_o), 512'(model_q[0].ras_tos));
                check("rnd_ghist", 512'(bus.global_history_o_2),   512'(model_q[0].lane[2].ghist));
            end else begin
                check("rnd_empty_valid", 512'(bus.dec_valid_o), 512'(3'b000));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
